timer_dev: RTL and testbench
============================

Name: timer_dev

Overview:
- Memory-mapped countdown timer on the processor-side device bus.
- Acts as the responder to the CPU's PrAddr/PrWE/PrWD/PrRD transactions; the system bridge decodes the device window and supplies the word offset.
- Drives one hardware interrupt line into the CPU's HWInt[15:10] vector.
- Supports one-shot and auto-reload modes.

Parameters:
- CTRL_BITS, 4, number of implemented CTRL bits; CTRL bits above this are not stored and read as 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  2  word offset within the device, equal to PrAddr[3:2]. 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- we  in  1  write strobe, already qualified by the bridge; a write completes in the same cycle.
- wd  in  32  write data.
- rd  out  32  read data; combinational from addr, no wait states.
- irq  out  1  interrupt request to the CPU.

Behaviour:
- Reset (reset=0, asynchronous):
  - CTRL=0, PRESET=0, COUNT=0.
  - State=IDLE, irq_flag=0, irq=0.
- Register map:
  - CTRL[0] = EN.
  - CTRL[2:1] = MODE: 00 = one-shot; 01 = auto-reload; 10 and 11 behave as 00.
  - CTRL[3] = IM, interrupt mask; 1 enables irq.
  - PRESET = reload value.
  - COUNT is read-only; writes to COUNT and to offset 3 are ignored.
  - Offset 3 reads 0.
- Bus writes:
  - Register contents update at the edge after we=1.
  - A PRESET write never disturbs a count in progress; the new value is used at the next LOAD.
- FSM: IDLE, LOAD, CNT, INT. All decisions use the registered CTRL.
  - IDLE: if EN → LOAD.
  - LOAD: COUNT ← PRESET; → CNT.
  - CNT:
    - if !EN → IDLE, COUNT holds.
    - else if COUNT > 1: COUNT ← COUNT−1, stay in CNT.
    - else (COUNT ≤ 1): COUNT ← 0; → INT.
    - A PRESET of 0 therefore reaches INT one cycle after LOAD, with the same latency as PRESET=1.
  - INT, MODE=00:
    - irq_flag ← 1.
    - CTRL.EN ← 0.
    - → IDLE.
  - INT, MODE=01:
    - irq_pulse asserted for exactly this cycle.
    - → LOAD if EN, else → IDLE.
- irq = IM & (irq_flag | irq_pulse).
  - irq_flag is level-sensitive and stays high until any write to CTRL or PRESET clears it.
  - In auto-reload mode irq is a one-cycle pulse per period.
- Period in auto-reload mode: PRESET+2 cycles for PRESET ≥ 1.
- Simultaneous events:
  - A bus write to CTRL in the same cycle as INT clearing EN: the bus write wins.
  - A CTRL/PRESET write in the same cycle as INT setting irq_flag: the set wins, so the flag is 1 afterwards.
- Disabling mid-count: a CTRL write with EN=0 takes effect at CNT on the next cycle; COUNT freezes at its current value. Re-enabling restarts from LOAD, not from the frozen COUNT.
- Wrap-around: COUNT never decrements below 0.
- Reset mid-operation: all state returns immediately to the reset values above.

Decomposition:
- Shared package holds:
  - Offset constants: ADDR_CTRL=2'd0, ADDR_PRESET=2'd1, ADDR_COUNT=2'd2.
  - Mode constants: MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01.
  - CTRL bit indices: EN, MODE_LO, MODE_HI, IM.
  - FSM state encodings (2-bit).
- The CPU bridge and the test bench reuse the same offset constants.
- No sub-module: register file, FSM and read mux fit in one module.

Test Plan:
- Reset then read: assert reset=0 for 2 cycles, release, read offsets 0/1/2/3 → rd=0 each; irq=0.
- One-shot timing:
  - Stimulus: write PRESET=5, then CTRL=0x9 (EN=1, MODE=00, IM=1).
  - Required: COUNT reads 5,4,3,2,1,0 on successive cycles after LOAD; irq rises 8 cycles after the CTRL write edge and stays 1; CTRL reads 0x8.
  - Then write CTRL=0 → irq falls next cycle.
- Auto-reload:
  - Stimulus: PRESET=3, CTRL=0xB.
  - Required: irq is a one-cycle pulse every 5 cycles, at least 4 periods; COUNT reloads to 3 each period.
- Mask and disable mid-count:
  - Stimulus: PRESET=100, CTRL=0x1 (IM=0); at COUNT=40 write CTRL=0.
  - Required: irq never asserts; COUNT holds 40 (±1 cycle of decrement before the freeze, exact value checked against the model).
  - Then write CTRL=0x1 → COUNT reloads to 100.
- Edge cases:
  - PRESET=0 in one-shot → reaches INT with the same latency as PRESET=1.
  - A write to COUNT (0x55) is ignored.
  - A CTRL write in the same cycle as INT leaves EN as written.
  - A PRESET write during CNT does not change the running COUNT.
- Asynchronous reset mid-count: drop reset between clock edges while COUNT=7 → all outputs 0 before the next edge.

Source files
------------

// File: rtl/timer_dev_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_dev_pkg
// Description : Shared constants for the memory-mapped countdown timer.
//               Word offsets are reused by the CPU bridge and test bench.
//               Contents: word offsets, MODE encodings, CTRL bit indices,
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_dev_pkg;

   // Word offsets within the device window (PrAddr[3:2])
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_RSVD   = 2'd3;

   // CTRL.MODE encodings; 2'b10 and 2'b11 fall back to one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // CTRL bit indices
   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   // Timer FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

endpackage : timer_dev_pkg
`default_nettype wire

// File: rtl/timer_dev.sv
`default_nettype none
// ============================================================================
// Module      : timer_dev
// Description : Memory-mapped countdown timer with one-shot and auto-reload
//               modes and one maskable interrupt line.
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous active-low reset
//               addr   - word offset (0=CTRL, 1=PRESET, 2=COUNT, 3=reserved)
//               we     - bus write strobe, completes in the same cycle
//               wd     - bus write data
//               rd     - combinational read data selected by addr
//               irq    - interrupt request to the CPU
// Revision    : 1.0 - initial release
// ============================================================================
module timer_dev
   import timer_dev_pkg::*;
#(
   parameter int CTRL_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        irq
);

   logic [CTRL_BITS-1:0] r_ctrl;
   logic [31:0]          r_preset;
   logic [31:0]          r_count;
   logic                 r_irq_flag;
   state_t               r_state;

   logic                 w_wr_ctrl;
   logic                 w_wr_preset;
   logic                 w_en;
   logic                 w_im;
   logic                 w_reload;
   logic                 w_irq_pulse;

   assign w_wr_ctrl   = we && (addr == ADDR_CTRL);
   assign w_wr_preset = we && (addr == ADDR_PRESET);

   // All FSM decisions come from the registered CTRL, never from wd
   assign w_en        = r_ctrl[CTRL_EN];
   assign w_im        = r_ctrl[CTRL_IM];
   assign w_reload    = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

   // Auto-reload interrupt lasts exactly the INT cycle
   assign w_irq_pulse = (r_state == ST_INT) && w_reload;
   assign irq         = w_im && (r_irq_flag || w_irq_pulse);

   always_comb begin
      rd = '0;
      case (addr)
         ADDR_CTRL:   rd[CTRL_BITS-1:0] = r_ctrl;
         ADDR_PRESET: rd = r_preset;
         ADDR_COUNT:  rd = r_count;
         default:     rd = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ctrl     <= '0;
         r_preset   <= '0;
         r_count    <= '0;
         r_irq_flag <= 1'b0;
         r_state    <= ST_IDLE;
      end else begin
         if (w_wr_ctrl) begin
            r_ctrl <= wd[CTRL_BITS-1:0];
         end
         if (w_wr_preset) begin
            r_preset <= wd;
         end
         // Any CTRL/PRESET write acknowledges the flag; a set in INT below
         // is assigned later and therefore wins in the same cycle.
         if (w_wr_ctrl || w_wr_preset) begin
            r_irq_flag <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_en) begin
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_count <= r_preset;
               r_state <= ST_CNT;
            end
            ST_CNT: begin
               if (!w_en) begin
                  r_state <= ST_IDLE;          // COUNT freezes
               end else if (r_count > 32'd1) begin
                  r_count <= r_count - 32'd1;
               end else begin
                  // Covers PRESET=0 too, so COUNT never wraps below zero
                  r_count <= '0;
                  r_state <= ST_INT;
               end
            end
            ST_INT: begin
               if (w_reload) begin
                  r_state <= w_en ? ST_LOAD : ST_IDLE;
               end else begin
                  r_irq_flag <= 1'b1;
                  // A simultaneous bus write to CTRL keeps the written EN
                  if (!w_wr_ctrl) begin
                     r_ctrl[CTRL_EN] <= 1'b0;
                  end
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule : timer_dev
`default_nettype wire

// File: tb/tb_timer_dev.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_dev
// Description : Self-checking bench for timer_dev: a table of per-cycle
//               bus vectors for reset/one-shot/register-map behaviour, then
//               hand-written sequences for the multi-cycle corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_dev;
   import timer_dev_pkg::*;

   logic        clk;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        irq;

   int n_chk = 0;
   int n_err = 0;

   timer_dev #(.CTRL_BITS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wd    (wd),
      .rd    (rd),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  waddr;
      logic [31:0] wd;
      logic [1:0]  raddr;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(input string n, input logic w, input logic [1:0] wa,
                               input logic [31:0] d, input logic [1:0] ra,
                               input logic [31:0] er, input logic ei);
      vec_t v;
      v.name = n; v.we = w; v.waddr = wa; v.wd = d;
      v.raddr = ra; v.exp_rd = er; v.exp_irq = ei;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // One bus cycle: drive before the edge, then select the read offset and
   // sample 2 time units after the edge.
   task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic [1:0] ra);
      we = w; addr = a; wd = d;
      @(posedge clk);
      #1;
      we = 1'b0; addr = ra;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, ADDR_CTRL, 32'h0, ADDR_COUNT);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k_first;
      int guard;
      logic [31:0] exp_cnt;

      // ---------------- vector table ----------------
      tbl[0]  = mk("rst_ctrl",    0, ADDR_CTRL,   32'h0,        ADDR_CTRL,   32'h0, 0);
      tbl[1]  = mk("rst_preset",  0, ADDR_CTRL,   32'h0,        ADDR_PRESET, 32'h0, 0);
      tbl[2]  = mk("rst_count",   0, ADDR_CTRL,   32'h0,        ADDR_COUNT,  32'h0, 0);
      tbl[3]  = mk("rst_rsvd",    0, ADDR_CTRL,   32'h0,        ADDR_RSVD,   32'h0, 0);
      tbl[4]  = mk("os_preset",   1, ADDR_PRESET, 32'd5,        ADDR_PRESET, 32'd5, 0);
      tbl[5]  = mk("os_ctrl",     1, ADDR_CTRL,   32'h9,        ADDR_CTRL,   32'h9, 0);
      tbl[6]  = mk("os_load",     0, ADDR_CTRL,   32'h0,        ADDR_COUNT,  32'd0, 0);
      tbl[7]  = mk("os_cnt5",     0, ADDR_CTRL,   32'h0,        ADDR_COUNT,  32'd5, 0);
      tbl[8]  = mk("os_cnt4",     0, ADDR_CTRL,   32'h0,        ADDR_COUNT,  32'd4, 0);
      tbl[9]  = mk("os_cnt3",     0, ADDR_CTRL,   32'h0,        ADDR_COUNT,  32'd3, 0);
      tbl[10] = mk("os_cnt2",     0, ADDR_CTRL,   32'h0,        ADDR_COUNT,  32'd2, 0);
      tbl[11] = mk("os_cnt1",     0, ADDR_CTRL,   32'h0,        ADDR_COUNT,  32'd1, 0);
      tbl[12] = mk("os_cnt0_int", 0, ADDR_CTRL,   32'h0,        ADDR_COUNT,  32'd0, 0);
      tbl[13] = mk("os_irq_ctrl", 0, ADDR_CTRL,   32'h0,        ADDR_CTRL,   32'h8, 1);
      tbl[14] = mk("os_irq_hold", 0, ADDR_CTRL,   32'h0,        ADDR_COUNT,  32'd0, 1);
      tbl[15] = mk("os_irq_clr",  1, ADDR_CTRL,   32'h0,        ADDR_CTRL,   32'h0, 0);
      tbl[16] = mk("wr_count",    1, ADDR_COUNT,  32'h55,       ADDR_COUNT,  32'h0, 0);
      tbl[17] = mk("wr_rsvd",     1, ADDR_RSVD,   32'hFFFFFFFF, ADDR_RSVD,   32'h0, 0);
      tbl[18] = mk("ctrl_mask",   1, ADDR_CTRL,   32'hFFFFFFF6, ADDR_CTRL,   32'h6, 0);
      tbl[19] = mk("ctrl_zero",   1, ADDR_CTRL,   32'h0,        ADDR_CTRL,   32'h0, 0);

      // ---------------- reset ----------------
      reset = 1'b0; we = 1'b0; addr = ADDR_CTRL; wd = 32'h0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      #1;

      foreach (tbl[i]) begin
         step(tbl[i].we, tbl[i].waddr, tbl[i].wd, tbl[i].raddr);
         chk({tbl[i].name, "_rd"}, rd, tbl[i].exp_rd);
         chk({tbl[i].name, "_irq"}, {31'd0, irq}, {31'd0, tbl[i].exp_irq});
      end

      // ---------------- auto-reload: PRESET=3, period 5 ----------------
      step(1, ADDR_PRESET, 32'd3, ADDR_COUNT);
      step(1, ADDR_CTRL, 32'hB, ADDR_COUNT);          // k = 1
      for (int k = 2; k <= 23; k++) begin
         step(0, ADDR_CTRL, 32'h0, ADDR_COUNT);
         chk($sformatf("ar_irq_k%0d", k), {31'd0, irq},
             {31'd0, (k >= 6 && (k - 6) % 5 == 0)});
         if (k >= 3) begin
            exp_cnt = ((k - 3) % 5 < 3) ? 32'(3 - (k - 3) % 5) : 32'd0;
            chk($sformatf("ar_cnt_k%0d", k), rd, exp_cnt);
         end
      end
      step(1, ADDR_CTRL, 32'h0, ADDR_COUNT);
      idle(4);

      // ---------------- masked count, disable at 40 ----------------
      step(1, ADDR_PRESET, 32'd100, ADDR_COUNT);
      step(1, ADDR_CTRL, 32'h1, ADDR_COUNT);
      guard = 0;
      while (rd !== 32'd40 && guard < 300) begin
         chk("mask_irq_low", {31'd0, irq}, 32'd0);
         step(0, ADDR_CTRL, 32'h0, ADDR_COUNT);
         guard++;
      end
      if (guard >= 300) chk("mask_reach40_timeout", rd, 32'd40);
      step(1, ADDR_CTRL, 32'h0, ADDR_COUNT);          // EN still 1 at this edge
      chk("dis_cnt_a", rd, 32'd39);
      step(0, ADDR_CTRL, 32'h0, ADDR_COUNT);
      chk("dis_cnt_frozen", rd, 32'd39);
      step(1, ADDR_COUNT, 32'h55, ADDR_COUNT);
      chk("count_write_ignored", rd, 32'd39);
      chk("mask_irq_end", {31'd0, irq}, 32'd0);
      step(1, ADDR_CTRL, 32'h1, ADDR_COUNT);
      chk("reen_k1", rd, 32'd39);
      step(0, ADDR_CTRL, 32'h0, ADDR_COUNT);
      chk("reen_k2", rd, 32'd39);
      step(0, ADDR_CTRL, 32'h0, ADDR_COUNT);
      chk("reen_reload", rd, 32'd100);
      step(1, ADDR_CTRL, 32'h0, ADDR_COUNT);
      idle(3);

      // ---------------- PRESET=1 and PRESET=0 latency ----------------
      for (int p = 1; p >= 0; p--) begin
         step(1, ADDR_PRESET, 32'(p), ADDR_COUNT);
         step(1, ADDR_CTRL, 32'h9, ADDR_COUNT);       // k = 1
         k_first = 0;
         for (int k = 2; k <= 20 && k_first == 0; k++) begin
            step(0, ADDR_CTRL, 32'h0, ADDR_COUNT);
            if (irq === 1'b1) k_first = k;
         end
         chk($sformatf("latency_preset%0d", p), 32'(k_first), 32'd5);
         step(1, ADDR_CTRL, 32'h0, ADDR_COUNT);
         idle(2);
      end

      // ---------------- CTRL write in the INT cycle ----------------
      step(1, ADDR_PRESET, 32'd2, ADDR_COUNT);
      step(1, ADDR_CTRL, 32'h9, ADDR_COUNT);          // k = 1
      idle(4);                                         // k = 2..5, INT after k=5
      chk("int_cnt0", rd, 32'd0);
      chk("int_irq_pre", {31'd0, irq}, 32'd0);
      step(1, ADDR_CTRL, 32'h9, ADDR_CTRL);           // k = 6
      chk("int_ctrl_wins", rd, 32'h9);
      chk("int_flag_wins", {31'd0, irq}, 32'd1);
      step(1, ADDR_CTRL, 32'h0, ADDR_CTRL);
      chk("int_irq_clr", {31'd0, irq}, 32'd0);
      idle(3);

      // ---------------- PRESET write mid-count, then async reset ----------------
      step(1, ADDR_PRESET, 32'd10, ADDR_COUNT);
      step(1, ADDR_CTRL, 32'h9, ADDR_COUNT);          // k = 1
      idle(3);                                         // k = 2..4
      chk("pw_cnt9", rd, 32'd9);
      step(1, ADDR_PRESET, 32'd77, ADDR_COUNT);       // k = 5
      chk("pw_cnt8", rd, 32'd8);
      step(0, ADDR_CTRL, 32'h0, ADDR_COUNT);          // k = 6
      chk("pw_cnt7", rd, 32'd7);
      addr = ADDR_PRESET;
      #1;
      chk("pw_preset77", rd, 32'd77);
      reset = 1'b0;                                    // between clock edges
      addr = ADDR_COUNT;
      #1;
      chk("arst_count", rd, 32'd0);
      chk("arst_irq", {31'd0, irq}, 32'd0);
      addr = ADDR_PRESET;
      #1;
      chk("arst_preset", rd, 32'd0);
      addr = ADDR_CTRL;
      #1;
      chk("arst_ctrl", rd, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      idle(3);
      chk("post_rst_count", rd, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_timer_dev
`default_nettype wire
